// File: rtl/sdf_delay_line.sv
// SDF delay line: circular buffer delaying complex samples
// by DEPTH enabled cycles, with fill tracking and gating.
module sdf_delay_line #(
  parameter int DATA_W = 36,
  parameter int DEPTH  = 4,
  parameter int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEn,
  input  logic              iFlush,
  input  logic [DATA_W-1:0] iData_Re,
  input  logic [DATA_W-1:0] iData_Im,
  output logic [DATA_W-1:0] oData_Re,
  output logic [DATA_W-1:0] oData_Im,
  output logic              oValid,
  output logic [FILL_W-1:0] oFill
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENT_W = 2 * DATA_W;

  localparam logic [PTR_W-1:0] PTR_LAST =
    PTR_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX =
    FILL_W'(DEPTH);

  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0]  ptr_d, ptr_q;
  logic [FILL_W-1:0] fill_d, fill_q;
  logic              wr_en;
  logic              valid;
  logic [ENT_W-1:0]  rd_data;

  // Next pointer/fill: flush wins over enable; wrap
  // compares against DEPTH-1 so odd depths stay exact.
  always_comb begin
    wr_en  = iEn & ~iFlush;
    ptr_d  = ptr_q;
    fill_d = fill_q;
    if (iFlush) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (iEn) begin
      if (ptr_q == PTR_LAST) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  // Pointer and fill state, cleared asynchronously.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      ptr_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
    end
  end

  // Sample storage is never cleared; the fill gate
  // keeps stale entries off the outputs.
  always_ff @(posedge iClk) begin
    if (wr_en) begin
      mem_q[ptr_q] <= {iData_Re, iData_Im};
    end
  end

  // Oldest entry sits at the write pointer once full.
  always_comb begin
    valid   = (fill_q == FILL_MAX);
    rd_data = '0;
    if (valid) begin
      rd_data = mem_q[ptr_q];
    end
  end

  assign oValid   = valid;
  assign oFill    = fill_q;
  assign oData_Re = rd_data[ENT_W-1:DATA_W];
  assign oData_Im = rd_data[DATA_W-1:0];

endmodule

// File: tb/tb_sdf_delay_line.sv
// Directed bench for sdf_delay_line at several
// depths and widths, against hand values and a model.
module tb_sdf_delay_line;

  logic clk;
  logic rst_n;

  logic        en4, fl4;
  logic [35:0] re4, im4, ore4, oim4;
  logic        ov4;
  logic [2:0]  of4;

  logic        en3, fl3;
  logic [15:0] re3, im3, ore3, oim3;
  logic        ov3;
  logic [1:0]  of3;

  logic        en1, fl1;
  logic [15:0] re1, im1, ore1, oim1;
  logic        ov1;
  logic [0:0]  of1;

  logic        en16, fl16;
  logic [17:0] re16, im16, ore16, oim16;
  logic        ov16;
  logic [4:0]  of16;

  int n_chk;
  int n_err;

  sdf_delay_line #(.DATA_W(36), .DEPTH(4)) u_d4 (
    .iClk(clk), .iRst_n(rst_n),
    .iEn(en4), .iFlush(fl4),
    .iData_Re(re4), .iData_Im(im4),
    .oData_Re(ore4), .oData_Im(oim4),
    .oValid(ov4), .oFill(of4)
  );

  sdf_delay_line #(.DATA_W(16), .DEPTH(3)) u_d3 (
    .iClk(clk), .iRst_n(rst_n),
    .iEn(en3), .iFlush(fl3),
    .iData_Re(re3), .iData_Im(im3),
    .oData_Re(ore3), .oData_Im(oim3),
    .oValid(ov3), .oFill(of3)
  );

  sdf_delay_line #(.DATA_W(16), .DEPTH(1)) u_d1 (
    .iClk(clk), .iRst_n(rst_n),
    .iEn(en1), .iFlush(fl1),
    .iData_Re(re1), .iData_Im(im1),
    .oData_Re(ore1), .oData_Im(oim1),
    .oValid(ov1), .oFill(of1)
  );

  sdf_delay_line #(.DATA_W(18), .DEPTH(16)) u_d16 (
    .iClk(clk), .iRst_n(rst_n),
    .iEn(en16), .iFlush(fl16),
    .iData_Re(re16), .iData_Im(im16),
    .oData_Re(ore16), .oData_Im(oim16),
    .oValid(ov16), .oFill(of16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic chk(
    input string      tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int gen  [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
  int gfil [8] = '{1, 1, 2, 3, 3, 3, 4, 4};
  int gout [8] = '{0, 0, 0, 0, 0, 0,
                   'hA0, 'hA2};

  logic [31:0] h3 [$];
  logic [31:0] h1 [$];
  int n;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    en4 = 1'b1; fl4 = 1'b0;
    re4 = 36'h9; im4 = 36'h9;
    en3 = 1'b0; fl3 = 1'b0; re3 = '0; im3 = '0;
    en1 = 1'b0; fl1 = 1'b0; re1 = '0; im1 = '0;
    en16 = 1'b0; fl16 = 1'b0;
    re16 = '0; im16 = '0;

    // reset state, enable ignored under reset
    #2;
    chk("rst_fill", of4, 0);
    chk("rst_valid", ov4, 0);
    chk("rst_re", ore4, 0);
    tick();
    chk("rst_hold_fill", of4, 0);
    chk("rst_fill16", of16, 0);
    rst_n = 1'b1;

    // continuous fill, Re=1..8, Im=Re+100
    for (int i = 1; i <= 8; i++) begin
      en4 = 1'b1;
      re4 = 36'(i);
      im4 = 36'(i + 100);
      tick();
      chk("fill_run", of4, (i < 4) ? i : 4);
      chk("valid_run", ov4, i >= 4);
      chk("re_run", ore4, (i >= 4) ? i - 3 : 0);
      chk("im_run", oim4,
          (i >= 4) ? i - 3 + 100 : 0);
    end

    // flush, then gapped enable A..H
    en4 = 1'b0; fl4 = 1'b1;
    tick();
    fl4 = 1'b0;
    chk("flush_fill", of4, 0);
    chk("flush_re", ore4, 0);
    for (int i = 0; i < 8; i++) begin
      en4 = gen[i][0];
      re4 = 36'('hA0 + i);
      im4 = 36'('hB0 + i);
      tick();
      chk("gap_fill", of4, gfil[i]);
      chk("gap_re", ore4, gout[i]);
    end
    en4 = 1'b0;
    re4 = 36'hFF;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("gap_hold_re", ore4, 'hA2);
      chk("gap_hold_im", oim4, 'hB2);
      chk("gap_hold_fill", of4, 4);
    end

    // flush with simultaneous enable drops 0x55
    en4 = 1'b1; fl4 = 1'b1;
    re4 = 36'h55; im4 = 36'h55;
    tick();
    fl4 = 1'b0;
    chk("fle_fill", of4, 0);
    chk("fle_valid", ov4, 0);
    chk("fle_re", ore4, 0);
    for (int i = 0; i < 5; i++) begin
      re4 = 36'('h60 + i);
      im4 = 36'('h60 + i);
      tick();
      chk("refill_re", ore4,
          (i >= 3) ? 'h60 + i - 3 : 0);
    end

    // async reset while streaming clears at once
    en4 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ars_valid", ov4, 0);
    chk("ars_re", ore4, 0);
    chk("ars_fill", of4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // async reset with two samples held
    en4 = 1'b1;
    for (int i = 0; i < 2; i++) begin
      re4 = 36'('h80 + i);
      tick();
    end
    en4 = 1'b0;
    chk("pre_rst_fill", of4, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("ar2_fill", of4, 0);
    chk("ar2_re", ore4, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // first edge after reset accepts a write
    en4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      re4 = 36'('h70 + i);
      im4 = 36'('h170 + i);
      tick();
      chk("post_rst_fill", of4, i + 1);
    end
    chk("post_rst_re", ore4, 'h70);
    chk("post_rst_im", oim4, 'h170);
    en4 = 1'b0;

    // depth 3 random stream vs shift model
    for (int i = 0; i < 20; i++) begin
      en3 = 1'b1;
      re3 = 16'($urandom);
      im3 = 16'($urandom);
      h3.push_back({re3, im3});
      tick();
      n = h3.size();
      chk("d3_fill", of3, (n < 3) ? n : 3);
      chk("d3_out", {ore3, oim3},
          (n >= 3) ? h3[n - 3] : 0);
    end
    en3 = 1'b0;

    // depth 1 random stream vs shift model
    for (int i = 0; i < 20; i++) begin
      en1 = 1'b1;
      re1 = 16'($urandom);
      im1 = 16'($urandom);
      h1.push_back({re1, im1});
      tick();
      n = h1.size();
      chk("d1_out", {ore1, oim1}, h1[n - 1]);
      chk("d1_valid", ov1, 1);
    end
    en1 = 1'b0;

    // 18-bit full-scale pass-through, depth 16
    for (int i = 0; i < 20; i++) begin
      en16 = 1'b1;
      re16 = i[0] ? 18'h20000 : 18'h1FFFF;
      im16 = i[0] ? 18'h1FFFF : 18'h20000;
      tick();
      n = i + 1;
      chk("d16_fill", of16, (n < 16) ? n : 16);
      if (n >= 16) begin
        chk("d16_re", ore16,
            ((n - 16) % 2 == 1) ? 'h20000 : 'h1FFFF);
        chk("d16_im", oim16,
            ((n - 16) % 2 == 1) ? 'h1FFFF : 'h20000);
      end
    end
    en16 = 1'b0;
    chk("d16_valid", ov16, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
